fan_tach_monitor: RTL and testbench

FAN_TACH_MONITOR -- requirements
Module: fan_tach_monitor

---
 rtl/fan_tach_monitor.sv | 214 +++++++++++++++++++++
 tb/tb_fan_tach_monitor.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fan_tach_monitor.sv
// fan_tach_monitor
//   Measures fan speed as tach pulses per fixed gate window and flags stalls.
//   The raw tach line is double-synchronized and debounced; every 1->0 edge of
//   the debounced level counts as one pulse. A gate counter closes a window
//   every GATE_CYCLES clocks, publishing the count with a one-cycle strobe.
//   A small FSM ignores the first SETTLE_WINDOWS windows after power-up and
//   then declares a stall after STALL_WINDOWS consecutive slow windows.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   tach_in      raw tachometer line (async, idle high)
//   fan_switch   fan powered
//   line_choice  00 two-line (no tach), 01 three-line, 10/11 four-line
//   tach_count   pulses in the last closed window
//   count_valid  one-cycle strobe when tach_count updates
//   stall        fan declared stalled (STALL state only)
//   state_out    00 IDLE, 01 SETTLE, 10 RUN, 11 STALL
module fan_tach_monitor #(
  parameter logic [23:0] GATE_CYCLES    = 24'd1_000_000,
  parameter int unsigned DEB_CYCLES     = 8,
  parameter logic [15:0] STALL_MIN      = 16'd2,
  parameter int unsigned STALL_WINDOWS  = 3,
  parameter int unsigned SETTLE_WINDOWS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tach_in,
  input  logic        fan_switch,
  input  logic [1:0]  line_choice,
  output logic [15:0] tach_count,
  output logic        count_valid,
  output logic        stall,
  output logic [1:0]  state_out
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SETTLE = 2'b01,
    S_RUN    = 2'b10,
    S_STALL  = 2'b11
  } state_t;

  localparam logic [3:0]  DEB_LIM    = 4'(DEB_CYCLES);
  localparam logic [23:0] GATE_LAST  = GATE_CYCLES - 24'd1;
  localparam logic [7:0]  SETTLE_LIM = 8'(SETTLE_WINDOWS);
  localparam logic [7:0]  STALL_LIM  = 8'(STALL_WINDOWS);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        filt_q, filt_d;
  logic        filt_dly_q, filt_dly_d;
  logic [3:0]  deb_cnt_q, deb_cnt_d;
  logic [23:0] gate_q, gate_d;
  logic [15:0] pulse_q, pulse_d;
  logic [15:0] tach_count_q, tach_count_d;
  logic        count_valid_q, count_valid_d;
  logic [7:0]  settle_q, settle_d;
  logic [7:0]  low_q, low_d;
  state_t      state_q, state_d;

  // ---------------------------------------------------------------------------
  // Synchronizer and debounce filter
  // ---------------------------------------------------------------------------
  always_comb begin
    sync1_d   = tach_in;
    sync2_d   = sync1_q;
    filt_d    = filt_q;
    deb_cnt_d = '0;
    // Counter tracks how many consecutive samples disagree with the accepted
    // level; any agreeing sample restarts the run, so short glitches vanish.
    if (sync2_q != filt_q) begin
      if (deb_cnt_q == DEB_LIM - 4'd1) filt_d = sync2_q;
      else                             deb_cnt_d = deb_cnt_q + 4'd1;
    end
    filt_dly_d = filt_q;
  end

  // Falling edge of the filtered level, registered one cycle after the
  // filter flips.
  logic fall;
  assign fall = filt_dly_q & ~filt_q;

  // ---------------------------------------------------------------------------
  // Gate window and pulse counter
  // ---------------------------------------------------------------------------
  logic        active;
  logic        running;
  logic        term;
  logic [15:0] pulse_inc;
  logic        low_window;

  assign active  = fan_switch & (line_choice != 2'b00);
  // The activation cycle itself (IDLE with active high) keeps counters at 0,
  // so the first window begins on the following cycle.
  assign running = active & (state_q != S_IDLE);
  assign term    = running & (gate_q == GATE_LAST);

  // Saturating add; the terminal-count cycle's pulse lands in the closing
  // window because the latched value already includes it.
  assign pulse_inc  = (pulse_q == 16'hFFFF) ? pulse_q : pulse_q + {15'd0, fall};
  assign low_window = pulse_inc < STALL_MIN;

  always_comb begin
    gate_d        = '0;
    pulse_d       = '0;
    tach_count_d  = tach_count_q;
    count_valid_d = 1'b0;
    if (running) begin
      if (term) begin
        tach_count_d  = pulse_inc;
        count_valid_d = 1'b1;
      end else begin
        gate_d  = gate_q + 24'd1;
        pulse_d = pulse_inc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    low_d    = low_q;
    if (!active) begin
      // Dropping active discards any window in progress, including one whose
      // terminal count coincides with the drop.
      state_d  = S_IDLE;
      settle_d = '0;
      low_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d  = S_SETTLE;
          settle_d = '0;
          low_d    = '0;
        end
        S_SETTLE: begin
          if (term) begin
            if (settle_q + 8'd1 >= SETTLE_LIM) begin
              state_d  = S_RUN;
              settle_d = '0;
              low_d    = '0;
            end else begin
              settle_d = settle_q + 8'd1;
            end
          end
        end
        S_RUN: begin
          if (term) begin
            if (low_window) begin
              low_d = low_q + 8'd1;
              if (low_q + 8'd1 >= STALL_LIM) state_d = S_STALL;
            end else begin
              low_d = '0;
            end
          end
        end
        S_STALL: begin
          // Any healthy window is enough to recover.
          if (term && !low_window) begin
            state_d = S_RUN;
            low_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      filt_q        <= 1'b1;
      filt_dly_q    <= 1'b1;
      deb_cnt_q     <= '0;
      gate_q        <= '0;
      pulse_q       <= '0;
      tach_count_q  <= '0;
      count_valid_q <= 1'b0;
      settle_q      <= '0;
      low_q         <= '0;
      state_q       <= S_IDLE;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      filt_q        <= filt_d;
      filt_dly_q    <= filt_dly_d;
      deb_cnt_q     <= deb_cnt_d;
      gate_q        <= gate_d;
      pulse_q       <= pulse_d;
      tach_count_q  <= tach_count_d;
      count_valid_q <= count_valid_d;
      settle_q      <= settle_d;
      low_q         <= low_d;
      state_q       <= state_d;
    end
  end

  assign tach_count  = tach_count_q;
  assign count_valid = count_valid_q;
  assign stall       = (state_q == S_STALL);
  assign state_out   = state_q;

endmodule

// File: tb/tb_fan_tach_monitor.sv
// Bench for fan_tach_monitor: table of whole-scenario vectors with hand
// expectations, hand sequences for multi-cycle corners, and a random phase.
// A cycle-level reference model (pulse-event queue plus window arithmetic)
// is checked every cycle throughout.
module tb_fan_tach_monitor;
  localparam int G = 100, DEB = 4, SMIN = 2, STW = 3, SW = 2;

  logic        clk = 1'b0;
  logic        rst_n, tach_in, fan_switch;
  logic [1:0]  line_choice;
  logic [15:0] tach_count;
  logic        count_valid, stall;
  logic [1:0]  state_out;

  always #5 clk = ~clk;

  fan_tach_monitor #(
    .GATE_CYCLES(24'd100), .DEB_CYCLES(4), .STALL_MIN(16'd2),
    .STALL_WINDOWS(3), .SETTLE_WINDOWS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tach_in(tach_in), .fan_switch(fan_switch),
    .line_choice(line_choice), .tach_count(tach_count),
    .count_valid(count_valid), .stall(stall), .state_out(state_out)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0, cv_hits = 0;

  // Reference model: drive index -> accepted-fall events (edge numbers at
  // which the pulse is counted); windows close every G edges after the
  // activation edge; state follows from window ordinal and the run of slow
  // windows since the last healthy one.
  logic       mf;
  int         mrun, m_a, m_closed, m_lowrun;
  int         ev[$];
  logic [1:0] m_state;
  logic [15:0] m_tach;
  logic       m_cv, pact;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    mf = 1'b1; mrun = 0; ev.delete(); m_state = 2'd0; m_tach = '0; m_cv = 1'b0;
    m_closed = 0; m_lowrun = 0; pact = 1'b0; m_a = 0;
  endfunction

  function automatic void purge(input int e);
    while (ev.size() > 0 && ev[0] <= e) void'(ev.pop_front());
  endfunction

  function automatic void model_edge(input int e);
    int n;
    m_cv = 1'b0;
    if (!pact) begin
      m_state = 2'd0; purge(e);
    end else if (m_state == 2'd0) begin
      m_state = 2'd1; m_a = e; m_closed = 0; m_lowrun = 0; purge(e);
    end else if ((e - m_a) % G == 0) begin
      n = 0;
      foreach (ev[i]) if (ev[i] <= e) n++;
      purge(e);
      if (n > 65535) n = 65535;
      m_tach = 16'(n); m_cv = 1'b1; m_closed++;
      if (m_closed > SW) m_lowrun = (n < SMIN) ? m_lowrun + 1 : 0;
      m_state = (m_closed < SW) ? 2'd1 : (m_lowrun >= STW ? 2'd3 : 2'd2);
    end
  endfunction

  // A level is accepted after DEB consecutive driven samples of it; the
  // resulting pulse is counted 4 edges after the last of those samples
  // (two sync stages, filter update, edge detect).
  function automatic void model_tach(input logic t, input int n);
    if (t != mf) begin
      mrun++;
      if (mrun == DEB) begin
        mf = t; mrun = 0;
        if (t == 1'b0) ev.push_back(n + 4);
      end
    end else mrun = 0;
  endfunction

  task automatic step(input logic t, input logic f, input logic [1:0] l);
    @(posedge clk); cyc++; model_edge(cyc);
    #1 tach_in = t; fan_switch = f; line_choice = l;
    model_tach(t, cyc); pact = f && (l != 2'b00);
    @(negedge clk);
    if (count_valid) cv_hits++;
    chk("count_valid", count_valid, m_cv);
    chk("tach_count", tach_count, m_tach);
    chk("state_out", state_out, m_state);
    chk("stall", stall, m_state == 2'd3);
  endtask

  function automatic logic pat(input int i, input int lo, input int hi);
    if (lo == 0) return 1'b1;
    return ((i % (lo + hi)) < lo) ? 1'b0 : 1'b1;
  endfunction

  task automatic run_pat(input logic f, input logic [1:0] l, input int lo, input int hi, input int n);
    for (int i = 0; i < n; i++) step(pat(i, lo, hi), f, l);
  endtask

  task automatic go_idle();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 2'b00);
  endtask

  typedef struct {
    logic        fan;
    logic [1:0]  line;
    int          lo, hi, nwin;
    logic [15:0] exp_cnt;
    logic [1:0]  exp_state;
    logic        exp_stall;
  } vec_t;
  vec_t tbl[8];

  initial begin
    // Each vector starts from IDLE and runs nwin full windows plus the
    // activation cycle; the last two rely on tach_count held from vector 5.
    tbl[0] = '{1'b1, 2'b01, 10, 10, 3, 16'd5,  2'b10, 1'b0};
    tbl[1] = '{1'b1, 2'b10,  3, 17, 3, 16'd0,  2'b10, 1'b0}; // glitches only
    tbl[2] = '{1'b1, 2'b11,  0,  0, 5, 16'd0,  2'b11, 1'b1}; // steady high
    tbl[3] = '{1'b1, 2'b01, 25, 25, 6, 16'd2,  2'b10, 1'b0}; // exactly STALL_MIN
    tbl[4] = '{1'b1, 2'b01,  5, 95, 5, 16'd1,  2'b11, 1'b1}; // one below
    tbl[5] = '{1'b1, 2'b01,  4,  6, 3, 16'd10, 2'b10, 1'b0}; // low == DEB
    tbl[6] = '{1'b0, 2'b01, 10, 10, 3, 16'd10, 2'b00, 1'b0}; // fan off
    tbl[7] = '{1'b1, 2'b00, 10, 10, 3, 16'd10, 2'b00, 1'b0}; // two-line fan

    rst_n = 1'b1; tach_in = 1'b1; fan_switch = 1'b0; line_choice = 2'b00;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tach_count", tach_count, 0);
    chk("rst_count_valid", count_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_state", state_out, 0);
    repeat (2) begin @(posedge clk); cyc++; end
    #1 rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      go_idle();
      run_pat(tbl[v].fan, tbl[v].line, tbl[v].lo, tbl[v].hi, tbl[v].nwin * G + 2);
      chk($sformatf("vec%0d_count", v), tach_count, tbl[v].exp_cnt);
      chk($sformatf("vec%0d_state", v), state_out, tbl[v].exp_state);
      chk($sformatf("vec%0d_stall", v), stall, tbl[v].exp_stall);
    end

    // Stall, then recovery on a single 4-pulse window.
    go_idle();
    run_pat(1'b1, 2'b01, 0, 0, 5 * G + 2);
    chk("stall_enter", stall, 1);
    chk("stall_enter_cv", count_valid, 1);
    run_pat(1'b1, 2'b01, 10, 15, G);
    chk("stall_exit_cv", count_valid, 1);
    chk("stall_exit_count", tach_count, 4);
    chk("stall_exit_state", state_out, 2'b10);
    chk("stall_exit_stall", stall, 0);

    // Deactivate mid-window: nothing published, count held.
    go_idle();
    run_pat(1'b1, 2'b01, 10, 10, G + 51);
    chk("mid_first_count", tach_count, 5);
    cv_hits = 0;
    run_pat(1'b1, 2'b00, 10, 10, 120);
    chk("mid_drop_cv_hits", cv_hits, 0);
    chk("mid_drop_state", state_out, 0);
    chk("mid_drop_count", tach_count, 5);

    // Deactivate exactly on the terminal-count cycle: window discarded.
    go_idle();
    cv_hits = 0;
    run_pat(1'b1, 2'b01, 10, 15, G);
    step(1'b1, 1'b0, 2'b01);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 2'b01);
    chk("term_drop_cv_hits", cv_hits, 0);
    chk("term_drop_count", tach_count, 5);

    // Single pulse counted on the terminal-count edge belongs to window 1.
    go_idle();
    for (int i = 0; i <= 2 * G + 1; i++) begin
      step((i >= G - DEB - 2 && i < G - DEB + 8) ? 1'b0 : 1'b1, 1'b1, 2'b01);
      if (i == G + 1) begin
        chk("edge_win1_cv", count_valid, 1);
        chk("edge_win1_count", tach_count, 1);
      end
      if (i == 2 * G + 1) chk("edge_win2_count", tach_count, 0);
    end

    // Randomized segments, including glitches and activity changes.
    begin
      logic lvl = 1'b0, f = 1'b1;
      logic [1:0] l = 2'b01;
      for (int s = 0; s < 150; s++) begin
        int len = $urandom_range(1, 30);
        if ($urandom_range(0, 9) == 0) begin
          f = ($urandom_range(0, 7) != 0);
          l = 2'($urandom_range(0, 3));
          if ($urandom_range(0, 1) == 0 && l == 2'b00) l = 2'b01;
        end
        for (int i = 0; i < len; i++) step(lvl, f, l);
        lvl = ~lvl;
      end
    end

    // Asynchronous reset mid-window with tach toggling, right on a strobe.
    go_idle();
    run_pat(1'b1, 2'b01, 10, 10, 2 * G + 2);
    chk("pre_rst_state", state_out, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("arst_tach_count", tach_count, 0);
    chk("arst_count_valid", count_valid, 0);
    chk("arst_stall", stall, 0);
    chk("arst_state", state_out, 0);
    tach_in = 1'b1; fan_switch = 1'b0; line_choice = 2'b00;
    repeat (3) begin @(posedge clk); cyc++; end
    #1 rst_n = 1'b1;
    model_reset();
    run_pat(1'b1, 2'b01, 10, 10, 3 * G + 2);
    chk("post_rst_count", tach_count, 5);
    chk("post_rst_state", state_out, 2'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
